axis_burst_source: RTL and testbench
====================================

# axis_burst_source

- Single-clock AXI-Stream master that generates framed bursts of incrementing data words.
- Drives the slave write port of the memory wrapper: `m01_axis_*` connects to the wrapper's `s01_axis_*`.
- Used to load memory contents and exercise the write path under back-pressure.
- A burst is launched by a one-cycle start request; completion is reported with a done pulse.

## Interface
- DATA_WIDTH, 32: stream data width in bits; must be a multiple of 8.
- LEN_WIDTH, 12: width of the burst-length input; bursts of 1 to 2^LEN_WIDTH-1 beats.
- m01_axis_aclk  in  1  clock; all logic is on the rising edge.
- m01_axis_areset  in  1  synchronous, active-high reset.
- start  in  1  burst request, sampled only in IDLE.
- burst_len  in  LEN_WIDTH  number of data beats; latched on an accepted start.
- base_data  in  DATA_WIDTH  data value of beat 0; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the final handshake completes.
- done  out  1  one-cycle pulse after the final handshake of a burst.
- m01_axis_tready  in  1  downstream ready.
- m01_axis_tdata  out  DATA_WIDTH  beat data.
- m01_axis_tstrb  out  DATA_WIDTH/8  always all-ones while tvalid is high, 0 otherwise.
- m01_axis_tvalid  out  1  beat valid.
- m01_axis_tlast  out  1  marks the final beat of the burst.

## Operation
- States are IDLE, SEND and (only with the macro) CSUM.
- IDLE:
  - All stream outputs and busy are 0.
  - start=1 with burst_len≠0: latch len and base, clear beat_cnt and sum, go to SEND.
  - start=1 with burst_len=0: ignored, no done pulse.
- SEND:
  - tvalid=1, tdata = base + beat_cnt, modulo 2^DATA_WIDTH (wraps silently).
  - A handshake is tvalid&tready in the same cycle. On each handshake: beat_cnt+1, sum += tdata.
  - tlast=1 when beat_cnt = len-1 (macro off).
  - Handshake on the last beat: go to IDLE (macro off) or CSUM (macro on).
- CSUM: see Configuration.
- AXI-Stream rules:
  - Once tvalid is high, tvalid, tdata and tlast stay stable until the handshake.
  - tvalid never depends combinationally on tready.
- start, burst_len and base_data are ignored while busy; changing them mid-burst has no effect.
- tready held low indefinitely: the block stalls on the current beat with no timeout.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, tstrb=0, busy=0, done=0, state=IDLE, counters=0.
- Reset mid-burst:
  - All outputs return to reset values at the next edge.
  - The burst is aborted and no done pulse is produced.
  - Reset takes priority over start in the same cycle.
- Start latency: start accepted at edge N gives tvalid=1 and busy=1 from cycle N+1.
- Throughput is one beat per cycle while tready=1. With tready constantly high, a len-L burst occupies exactly L cycles.
- Final handshake at edge M:
  - Cycle M+1: done=1, busy=0, tvalid=0.
  - A start in cycle M+1 is accepted, so the minimum gap between bursts is one idle cycle.
- done is registered and never asserted together with tvalid.

## Configuration
- Macro: AXIS_BURST_SOURCE_CSUM_EN.
- Defined:
  - After the last data beat, the block enters CSUM and emits one extra beat.
  - tdata = sum of all data beats modulo 2^DATA_WIDTH; tlast=1 on this beat only, not on the last data beat.
  - done follows the checksum handshake.
  - The burst occupies len+1 beats.
- Undefined:
  - The CSUM state and sum register are not synthesized.
  - tlast is on data beat len-1.

## Test plan
- Reset, then start, len=4, base=0x10, tready=1 → tdata 0x10,0x11,0x12,0x13 on 4 consecutive cycles; tlast on 0x13; done one cycle later.
- len=3, base=0x100, tready toggling 1,0,0,1,0,1 → exactly 3 handshakes (0x100,0x101,0x102); tdata/tvalid stable on every stalled cycle.
- base=0xFFFFFFFE, len=4 → tdata 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- start with len=0 → no tvalid, no done. A second start during a burst → ignored; beat count unchanged.
- Reset asserted after 2 of 8 beats → tvalid/tlast/busy low at the next edge; done never pulses; a fresh start then runs normally from its own base.
- CSUM_EN defined, base=1, len=3 → beats 1,2,3,6; tlast only on 6; done after the 4th handshake.

Source files
------------

// File: rtl/axis_burst_source.sv
// axis_burst_source: AXI-Stream master emitting framed bursts of incrementing words.
// Define AXIS_BURST_SOURCE_CSUM_EN to append a checksum beat carrying the sum of the data beats.
module axis_burst_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                    m01_axis_aclk,
    input  logic                    m01_axis_areset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    input  logic [DATA_WIDTH-1:0]   base_data,
    output logic                    busy,
    output logic                    done,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast
);
`ifdef AXIS_BURST_SOURCE_CSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
    logic [DATA_WIDTH-1:0] sum;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif
    state_t               state;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 hs;
    logic                 last;
    assign hs             = m01_axis_tvalid && m01_axis_tready;
    assign last           = beat_cnt == len - LEN_WIDTH'(1);
    assign m01_axis_tstrb = {(DATA_WIDTH/8){m01_axis_tvalid}};
    // tdata is kept as base + beat_cnt by incrementing it on every handshake
    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            state           <= IDLE;
            len             <= '0;
            beat_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            m01_axis_tdata  <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tlast  <= 1'b0;
`ifdef AXIS_BURST_SOURCE_CSUM_EN
            sum             <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && burst_len != '0) begin
                    state           <= SEND;
                    len             <= burst_len;
                    beat_cnt        <= '0;
                    busy            <= 1'b1;
                    m01_axis_tdata  <= base_data;
                    m01_axis_tvalid <= 1'b1;
`ifdef AXIS_BURST_SOURCE_CSUM_EN
                    m01_axis_tlast  <= 1'b0;
                    sum             <= '0;
`else
                    m01_axis_tlast  <= burst_len == LEN_WIDTH'(1);
`endif
                end
                SEND: if (hs) begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
`ifdef AXIS_BURST_SOURCE_CSUM_EN
                    sum      <= sum + m01_axis_tdata;
`endif
                    if (!last) begin
                        m01_axis_tdata <= m01_axis_tdata + DATA_WIDTH'(1);
`ifndef AXIS_BURST_SOURCE_CSUM_EN
                        m01_axis_tlast <= beat_cnt + LEN_WIDTH'(2) == len;
`endif
                    end else begin
`ifdef AXIS_BURST_SOURCE_CSUM_EN
                        state           <= CSUM;
                        m01_axis_tdata  <= sum + m01_axis_tdata;
                        m01_axis_tlast  <= 1'b1;
`else
                        state           <= IDLE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        m01_axis_tdata  <= '0;
                        m01_axis_tvalid <= 1'b0;
                        m01_axis_tlast  <= 1'b0;
`endif
                    end
                end
`ifdef AXIS_BURST_SOURCE_CSUM_EN
                CSUM: if (hs) begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    done            <= 1'b1;
                    m01_axis_tdata  <= '0;
                    m01_axis_tvalid <= 1'b0;
                    m01_axis_tlast  <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_burst_source.sv
// tb_axis_burst_source: randomized bench for axis_burst_source against a queue-based beat model.
module tb_axis_burst_source;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] burst_len;
    logic [31:0] base_data;
    logic        busy;
    logic        done;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tvalid;
    logic        tlast;
    int          checks = 0;
    int          failures = 0;

    axis_burst_source dut (
        .m01_axis_aclk(clk),
        .m01_axis_areset(rst),
        .start(start),
        .burst_len(burst_len),
        .base_data(base_data),
        .busy(busy),
        .done(done),
        .m01_axis_tready(tready),
        .m01_axis_tdata(tdata),
        .m01_axis_tstrb(tstrb),
        .m01_axis_tvalid(tvalid),
        .m01_axis_tlast(tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".tvalid"}, tvalid, 0);
        chk({tag, ".tlast"}, tlast, 0);
        chk({tag, ".tdata"}, tdata, 0);
        chk({tag, ".tstrb"}, tstrb, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, exp_done);
    endtask

    // mode 0: tready high; 1: random; 2: pattern bits LSB first, then high
    task automatic run_burst(input int len, input logic [31:0] base, input int mode, input logic [15:0] pat);
        logic [31:0] exp[$];
        logic [31:0] s = 0;
        int idx = 0;
        int cyc = 0;
        logic tr;
        for (int i = 0; i < len; i++) begin
            exp.push_back(base + 32'(i));
            s += base + 32'(i);
        end
`ifdef AXIS_BURST_SOURCE_CSUM_EN
        exp.push_back(s);
`endif
        start = 1; burst_len = 12'(len); base_data = base; tready = 0;
        @(negedge clk);
        start = 0;
        while (idx < exp.size() && cyc < 2000) begin
            chk("beat.tvalid", tvalid, 1);
            chk("beat.tdata", tdata, exp[idx]);
            chk("beat.tlast", tlast, idx == exp.size() - 1);
            chk("beat.tstrb", tstrb, 4'hf);
            chk("beat.busy", busy, 1);
            chk("beat.done", done, 0);
            tr = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : (cyc < 16 ? pat[cyc] : 1'b1);
            tready = tr;
            start = 1'($urandom % 2);
            burst_len = 12'($urandom_range(0, 20));
            base_data = $urandom;
            if (tr) idx++;
            @(negedge clk);
            cyc++;
        end
        chk("burst.completed", idx, exp.size());
        if (mode == 0) chk("burst.cycles", cyc, exp.size());
        start = 0; tready = 0;
        chk_idle("after", 1);
        @(negedge clk);
        chk("done.pulse_end", done, 0);
    endtask

    initial begin
        rst = 1; start = 0; burst_len = 0; base_data = 0; tready = 0;
        repeat (2) @(negedge clk);
        chk_idle("reset", 0);
        rst = 0;
        @(negedge clk);
        run_burst(4, 32'h10, 0, 0);
        run_burst(3, 32'h100, 2, 16'b101001);
        run_burst(4, 32'hFFFFFFFE, 0, 0);
        run_burst(1, 32'hABCD, 0, 0);
        start = 1; burst_len = 0; base_data = 32'h55;
        @(negedge clk);
        start = 0;
        repeat (3) begin
            chk_idle("len0", 0);
            @(negedge clk);
        end
        start = 1; burst_len = 8; base_data = 32'h200; tready = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("pre_rst.tdata", tdata, 32'h201);
        @(negedge clk);
        rst = 1; start = 1; burst_len = 5;
        @(negedge clk);
        chk_idle("mid_rst", 0);
        rst = 0; start = 0; tready = 0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("post_rst", 0);
        end
        run_burst(5, 32'h3000, 1, 0);
        for (int k = 0; k < 10; k++) begin
            run_burst($urandom_range(1, 20), $urandom, 1, 0);
            if (k % 3 == 0) @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
